// File: rtl/pipe_pkg.sv
// Shared types for the RV32 pipeline control slice: forwarding selects,
// hazard FSM states and the hard-wired zero register.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    MEM_WAIT
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// E1 operand forwarding select for one source register; the M stage result
// is younger than the W result, so it wins when both match.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && rd_m != REG_X0 && rd_m == rs)
      sel = FWD_M;
    else if (reg_write_w && rd_w != REG_X0 && rd_w == rs)
      sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer and forwarding select for the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REDIRECT_PENALTY = 1,
  parameter int unsigned MEM_TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e1,
  input  logic [4:0] rs2_e1,
  input  logic [4:0] rd_e1,
  input  logic       mem_read_e1,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  input  logic       mispredict_e1,
  input  logic       mem_req_m,
  input  logic       mem_ready_m,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e1,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e1,
  output logic [1:0] fwd_a_e1,
  output logic [1:0] fwd_b_e1,
  output logic       mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_memwait_cnt
`endif
);

  hz_state_e  state, state_nxt;
  logic [2:0] red_cnt, red_cnt_nxt;
  logic [7:0] wait_cnt;
  logic       timeout_q;
  logic       mem_wait, load_use, mp_taken;
  logic       st_f, st_d, st_e1, st_m, fl_d, fl_e1;
  fwd_sel_e   sel_a, sel_b;

  assign mem_wait = mem_req_m && !mem_ready_m;
  assign load_use = mem_read_e1 && rd_e1 != REG_X0 &&
                    (rd_e1 == rs1_d || rd_e1 == rs2_d);

  always_comb begin
    state_nxt   = state;
    red_cnt_nxt = red_cnt;
    mp_taken    = 1'b0;
    st_f        = 1'b0;
    st_d        = 1'b0;
    st_e1       = 1'b0;
    st_m        = 1'b0;
    fl_d        = 1'b0;
    fl_e1       = 1'b0;
    if (mem_wait) begin
      // whole pipe frozen; a pending mispredict in E1 is picked up on release
      st_f      = 1'b1;
      st_d      = 1'b1;
      st_e1     = 1'b1;
      st_m      = 1'b1;
      state_nxt = MEM_WAIT;
    end else if (mispredict_e1) begin
      fl_d        = 1'b1;
      fl_e1       = 1'b1;
      mp_taken    = 1'b1;
      red_cnt_nxt = 3'(REDIRECT_PENALTY - 1);
      state_nxt   = (REDIRECT_PENALTY > 1) ? REDIRECT : RUN;
    end else if (state == REDIRECT) begin
      fl_d        = 1'b1;
      red_cnt_nxt = red_cnt - 3'd1;
      if (red_cnt == 3'd1)
        state_nxt = RUN;
    end else begin
      state_nxt = RUN;
      if (load_use) begin
        st_f  = 1'b1;
        st_d  = 1'b1;
        fl_e1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      red_cnt   <= 3'd0;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      red_cnt <= red_cnt_nxt;
      if (mem_wait) begin
        if (wait_cnt != 8'hFF)
          wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt == 8'(MEM_TIMEOUT - 1))
          timeout_q <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  fwd_unit u_fwd_a (
    .rs          (rs1_e1),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (sel_a)
  );

  fwd_unit u_fwd_b (
    .rs          (rs2_e1),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (sel_b)
  );

  // all outputs are held low for the whole reset cycle
  assign stall_f     = !rst && st_f;
  assign stall_d     = !rst && st_d;
  assign stall_e1    = !rst && st_e1;
  assign stall_m     = !rst && st_m;
  assign flush_d     = !rst && fl_d;
  assign flush_e1    = !rst && fl_e1;
  assign fwd_a_e1    = rst ? 2'b00 : sel_a;
  assign fwd_b_e1    = rst ? 2'b00 : sel_b;
  assign mem_timeout = !rst && timeout_q;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt   <= 32'd0;
      perf_flush_cnt   <= 32'd0;
      perf_memwait_cnt <= 32'd0;
    end else begin
      if (st_f)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (mp_taken)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (mem_wait)
        perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: three instances (penalty 1, 3, 4,
// timeout 4) share inputs; expected output vectors are queued per step.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e1, rs2_e1, rd_e1, rd_m, rd_w;
  logic       mem_read_e1, reg_write_m, reg_write_w, mispredict_e1, mem_req_m, mem_ready_m;

  always #5 clk = ~clk;

  // packed view: {stall_f,stall_d,stall_e1,stall_m,flush_d,flush_e1,fwd_a[1:0],fwd_b[1:0],mem_timeout}
  localparam logic [10:0] Z  = 11'd0;
  localparam logic [10:0] LU = {4'b1100, 1'b0, 1'b1, 5'b0};
  localparam logic [10:0] MP = {4'b0000, 1'b1, 1'b1, 5'b0};
  localparam logic [10:0] FD = {4'b0000, 1'b1, 1'b0, 5'b0};
  localparam logic [10:0] ST = {4'b1111, 1'b0, 1'b0, 5'b0};
  localparam logic [10:0] TO = 11'd1;

  typedef struct {
    string       tag;
    logic [10:0] e1;
    logic [10:0] e3;
    logic [10:0] e4;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [10:0] obs1, obs3, obs4;

  logic [1:0] u_p1_fa, u_p1_fb, u_p3_fa, u_p3_fb, u_p4_fa, u_p4_fb;
  logic u_p1_sf, u_p1_sd, u_p1_se, u_p1_sm, u_p1_fd, u_p1_fe, u_p1_to;
  logic u_p3_sf, u_p3_sd, u_p3_se, u_p3_sm, u_p3_fd, u_p3_fe, u_p3_to;
  logic u_p4_sf, u_p4_sd, u_p4_se, u_p4_sm, u_p4_fd, u_p4_fe, u_p4_to;
`ifdef HAZARD_PERF_EN
  logic [31:0] u_p1_ps, u_p1_pf, u_p1_pm, u_p3_ps, u_p3_pf, u_p3_pm, u_p4_ps, u_p4_pf, u_p4_pm;
`endif

  hazard_ctrl #(.REDIRECT_PENALTY(1), .MEM_TIMEOUT(4)) u_p1 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e1(rs1_e1), .rs2_e1(rs2_e1),
    .rd_e1(rd_e1), .mem_read_e1(mem_read_e1), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .mispredict_e1(mispredict_e1),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_f(u_p1_sf), .stall_d(u_p1_sd), .stall_e1(u_p1_se), .stall_m(u_p1_sm),
    .flush_d(u_p1_fd), .flush_e1(u_p1_fe), .fwd_a_e1(u_p1_fa), .fwd_b_e1(u_p1_fb),
    .mem_timeout(u_p1_to)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(u_p1_ps), .perf_flush_cnt(u_p1_pf), .perf_memwait_cnt(u_p1_pm)
`endif
  );
  assign obs1 = {u_p1_sf, u_p1_sd, u_p1_se, u_p1_sm, u_p1_fd, u_p1_fe, u_p1_fa, u_p1_fb, u_p1_to};

  hazard_ctrl #(.REDIRECT_PENALTY(3), .MEM_TIMEOUT(4)) u_p3 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e1(rs1_e1), .rs2_e1(rs2_e1),
    .rd_e1(rd_e1), .mem_read_e1(mem_read_e1), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .mispredict_e1(mispredict_e1),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_f(u_p3_sf), .stall_d(u_p3_sd), .stall_e1(u_p3_se), .stall_m(u_p3_sm),
    .flush_d(u_p3_fd), .flush_e1(u_p3_fe), .fwd_a_e1(u_p3_fa), .fwd_b_e1(u_p3_fb),
    .mem_timeout(u_p3_to)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(u_p3_ps), .perf_flush_cnt(u_p3_pf), .perf_memwait_cnt(u_p3_pm)
`endif
  );
  assign obs3 = {u_p3_sf, u_p3_sd, u_p3_se, u_p3_sm, u_p3_fd, u_p3_fe, u_p3_fa, u_p3_fb, u_p3_to};

  hazard_ctrl #(.REDIRECT_PENALTY(4), .MEM_TIMEOUT(4)) u_p4 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e1(rs1_e1), .rs2_e1(rs2_e1),
    .rd_e1(rd_e1), .mem_read_e1(mem_read_e1), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .mispredict_e1(mispredict_e1),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_f(u_p4_sf), .stall_d(u_p4_sd), .stall_e1(u_p4_se), .stall_m(u_p4_sm),
    .flush_d(u_p4_fd), .flush_e1(u_p4_fe), .fwd_a_e1(u_p4_fa), .fwd_b_e1(u_p4_fb),
    .mem_timeout(u_p4_to)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(u_p4_ps), .perf_flush_cnt(u_p4_pf), .perf_memwait_cnt(u_p4_pm)
`endif
  );
  assign obs4 = {u_p4_sf, u_p4_sd, u_p4_se, u_p4_sm, u_p4_fd, u_p4_fe, u_p4_fa, u_p4_fb, u_p4_to};

  task automatic chk_one(input string tag, input string inst, input logic [10:0] obs, input logic [10:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s[%s] observed=%b expected=%b", tag, inst, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    tests_run++;
    assert (exp_q.size() != 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = exp_q.pop_front();
    chk_one(e.tag, "p1", obs1, e.e1);
    chk_one(e.tag, "p3", obs3, e.e3);
    chk_one(e.tag, "p4", obs4, e.e4);
  endtask

  task automatic step(input string tag, input logic [10:0] x1, input logic [10:0] x3, input logic [10:0] x4);
    exp_t e;
    e.tag = tag; e.e1 = x1; e.e3 = x3; e.e4 = x4;
    exp_q.push_back(e);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rs1_d = 0; rs2_d = 0; rs1_e1 = 0; rs2_e1 = 0; rd_e1 = 0; rd_m = 0; rd_w = 0;
    mem_read_e1 = 0; reg_write_m = 0; reg_write_w = 0; mispredict_e1 = 0;
    mem_req_m = 0; mem_ready_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr_in();
    @(posedge clk); #1;
    step("reset", Z, Z, Z);
    rst = 1'b0;
    step("idle", Z, Z, Z);

    mem_read_e1 = 1; rd_e1 = 5; rs1_d = 5;
    step("lu_rs1", LU, LU, LU);
    mem_read_e1 = 0;
    step("lu_after", Z, Z, Z);
    mem_read_e1 = 1; rd_e1 = 9; rs1_d = 1; rs2_d = 9;
    step("lu_rs2", LU, LU, LU);
    rd_e1 = 0; rs1_d = 0; rs2_d = 0;
    step("lu_x0", Z, Z, Z);
    mem_read_e1 = 0; rd_e1 = 9; rs2_d = 9;
    step("lu_noload", Z, Z, Z);
    clr_in();

    rd_m = 7; rd_w = 7; reg_write_m = 1; reg_write_w = 1; rs1_e1 = 7; rs2_e1 = 0;
    step("fwd_m_wins", {6'b0, 2'b10, 2'b00, 1'b0}, {6'b0, 2'b10, 2'b00, 1'b0}, {6'b0, 2'b10, 2'b00, 1'b0});
    rd_m = 3; rs2_e1 = 3;
    step("fwd_w_m", {6'b0, 2'b01, 2'b10, 1'b0}, {6'b0, 2'b01, 2'b10, 1'b0}, {6'b0, 2'b01, 2'b10, 1'b0});
    reg_write_m = 0;
    step("fwd_m_nowr", {6'b0, 2'b01, 2'b00, 1'b0}, {6'b0, 2'b01, 2'b00, 1'b0}, {6'b0, 2'b01, 2'b00, 1'b0});
    rd_m = 0; rd_w = 0; reg_write_m = 1; rs1_e1 = 0; rs2_e1 = 0;
    step("fwd_x0", Z, Z, Z);
    clr_in();

    mispredict_e1 = 1;
    step("redir_c0", MP, MP, MP);
    mispredict_e1 = 0;
    step("redir_c1", Z, FD, FD);
    step("redir_c2", Z, FD, FD);
    step("redir_c3", Z, Z, FD);
    step("redir_c4", Z, Z, Z);

    mispredict_e1 = 1; mem_read_e1 = 1; rd_e1 = 5; rs1_d = 5;
    step("mp_over_lu", MP, MP, MP);
    clr_in();
    step("restart_c1", Z, FD, FD);
    mispredict_e1 = 1;
    step("restart_mp", MP, MP, MP);
    mispredict_e1 = 0;
    step("restart_c3", Z, FD, FD);
    step("restart_c4", Z, FD, FD);
    step("restart_c5", Z, Z, FD);
    step("restart_c6", Z, Z, Z);

    mem_req_m = 1; mem_ready_m = 0; mispredict_e1 = 1;
    for (int i = 0; i < 4; i++) step("mw_mp_wait", ST, ST, ST);
    mem_ready_m = 1;
    step("mw_mp_release", MP | TO, MP | TO, MP | TO);
    clr_in();
    step("mw_redir_c1", TO, FD | TO, FD | TO);
    step("mw_redir_c2", TO, FD | TO, FD | TO);
    step("mw_redir_c3", TO, TO, FD | TO);
    step("to_sticky", TO, TO, TO);

    rst = 1;
    step("rst_to", Z, Z, Z);
    rst = 0;
    step("to_cleared", Z, Z, Z);

    mem_req_m = 1; mem_ready_m = 0;
    for (int i = 0; i < 3; i++) step("wait3", ST, ST, ST);
    mem_ready_m = 1;
    step("wait3_rel", Z, Z, Z);
    mem_req_m = 0; mem_ready_m = 0;
    step("wait3_idle", Z, Z, Z);

    mem_req_m = 1;
    step("wait6_c1", ST, ST, ST);
    mem_read_e1 = 1; rd_e1 = 5; rs1_d = 5;
    step("wait6_lu", ST, ST, ST);
    mem_read_e1 = 0; rd_e1 = 0; rs1_d = 0;
    step("wait6_c3", ST, ST, ST);
    step("wait6_c4", ST, ST, ST);
    step("wait6_c5", ST | TO, ST | TO, ST | TO);
    step("wait6_c6", ST | TO, ST | TO, ST | TO);
    mem_ready_m = 1;
    step("wait6_rel", TO, TO, TO);
    clr_in();
    step("wait6_sticky", TO, TO, TO);

    rst = 1;
    step("rst_pre", Z, Z, Z);
    rst = 0;
    mispredict_e1 = 1;
    step("rstmid_c0", MP, MP, MP);
    mispredict_e1 = 0;
    step("rstmid_c1", Z, FD, FD);
    rst = 1;
    step("rstmid_rst", Z, Z, Z);
    rst = 0;
    step("rstmid_c3", Z, Z, Z);
    step("rstmid_c4", Z, Z, Z);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
